// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
// State encoding, width helpers and lane-keep constants.
package fifo_pkg;

  typedef enum logic [1:0] {
    S_FILL,
    S_FULL,
    S_FLUSH
  } state_t;

  localparam int NPACK_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int tmr_w(input int t);
    return $clog2(t);
  endfunction

  localparam int CNT_W_DEF = cnt_w(NPACK_DEF);
  localparam int TMR_W_DEF = tmr_w(TIMEOUT_DEF);

  localparam logic [31:0] KEEP_ALL32 = '1;

  // Contiguous keep mask covering the low n lanes.
  function automatic logic [31:0] keep_mask(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_idle_timer.sv
// Idle timer: counts enabled cycles, pulses o_expire at TIMEOUT-1.
// Ports: i_clk, i_rst, i_clear, i_enable, o_expire.
module fifo_idle_timer
  import fifo_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int TW = tmr_w(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && r_cnt != LAST) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_expire = i_enable & (r_cnt == LAST);

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains bytes from the FIFO read port and packs NPACK lanes per word.
// Ports: FIFO read (emptyb/rreqb/rdatb), flush_req, out valid/ready slot.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DSIZE   = 8,
  parameter int NPACK   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clkb,
  input  logic                   rstb,
  input  logic                   emptyb,
  output logic                   rreqb,
  input  logic [DSIZE-1:0]       rdatb,
  input  logic                   flush_req,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DSIZE*NPACK-1:0] out_data,
  output logic [NPACK-1:0]       out_keep
);

  localparam int CW = cnt_w(NPACK);
  localparam int W  = DSIZE * NPACK;
  localparam logic [CW-1:0] CNT_LAST = CW'(NPACK - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(NPACK);
  localparam logic [NPACK-1:0] KEEP_ALL = NPACK'(KEEP_ALL32);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_rd_pend;
  logic            r_flush;
  logic [W-1:0]    r_asm;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [NPACK-1:0] r_out_keep;

  logic [W-1:0]    w_word;
  logic [NPACK-1:0] w_keep_part;
  logic            w_rreqb;
  logic            w_has_data;
  logic            w_complete;
  logic            w_free;
  logic            w_flush_set;
  logic            w_part_go;
  logic            w_tmr_en;
  logic            w_tmr_clr;
  logic            w_timeout;

  assign w_has_data = (r_cnt != '0);
  assign w_free     = ~r_out_valid | out_ready;

  // Lanes already issued or in flight must leave room for one more.
  assign w_rreqb = ~rstb & ~emptyb & ~r_flush
                 & (r_state == S_FILL)
                 & (({1'b0, r_cnt} + {{CW{1'b0}}, r_rd_pend})
                    < (CW + 1)'(NPACK));

  assign w_complete = r_rd_pend & (r_state == S_FILL)
                    & (r_cnt == CNT_LAST);

  // A flush that coincides with word completion is absorbed by it.
  assign w_flush_set = flush_req & (r_state == S_FILL)
                     & (w_has_data | r_rd_pend) & ~w_complete;

  assign w_part_go = (r_flush | w_timeout) & w_has_data
                   & ~r_rd_pend & (r_state == S_FILL);

  assign w_keep_part = NPACK'(keep_mask(int'(r_cnt)));

  assign w_tmr_en  = (r_state == S_FILL) & w_has_data
                   & (r_cnt < CNT_MAX) & ~r_rd_pend & ~w_rreqb;
  assign w_tmr_clr = r_rd_pend | ~w_has_data;

  // Assembly view including the byte landing this cycle.
  always_comb begin
    w_word = r_asm;
    for (int i = 0; i < NPACK; i++) begin
      if (r_rd_pend && r_cnt == CW'(i)) begin
        w_word[i*DSIZE +: DSIZE] = rdatb;
      end
    end
  end

  fifo_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk    (clkb),
    .i_rst    (rstb),
    .i_clear  (w_tmr_clr),
    .i_enable (w_tmr_en),
    .o_expire (w_timeout)
  );

  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      r_state     <= S_FILL;
      r_cnt       <= '0;
      r_rd_pend   <= 1'b0;
      r_flush     <= 1'b0;
      r_asm       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
    end else begin
      r_rd_pend <= w_rreqb;
      r_asm     <= w_word;
      if (r_rd_pend) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_flush_set) begin
        r_flush <= 1'b1;
      end
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        S_FILL: begin
          if (w_complete) begin
            r_flush <= 1'b0;
            if (w_free) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_word;
              r_out_keep  <= KEEP_ALL;
              r_cnt       <= '0;
              r_asm       <= '0;
            end else begin
              r_state <= S_FULL;
            end
          end else if (w_part_go) begin
            if (w_free) begin
              r_out_valid <= 1'b1;
              r_out_data  <= r_asm;
              r_out_keep  <= w_keep_part;
              r_cnt       <= '0;
              r_asm       <= '0;
              r_flush     <= 1'b0;
            end else begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FULL: begin
          if (w_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_asm;
            r_out_keep  <= KEEP_ALL;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_state     <= S_FILL;
          end
        end
        S_FLUSH: begin
          if (w_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_asm;
            r_out_keep  <= w_keep_part;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_flush     <= 1'b0;
            r_state     <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign rreqb     = w_rreqb;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed and randomized bench for fifo_rd_packer.
// Models the FIFO read port and records accepted words.
module tb_fifo_rd_packer;

  localparam int DS = 8;
  localparam int NP = 4;
  localparam int TO = 16;

  logic          clkb = 1'b0;
  logic          rstb;
  logic          emptyb = 1'b1;
  logic          rreqb;
  logic [DS-1:0] rdatb = '0;
  logic          flush_req;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [NP-1:0] out_keep;

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] got_d[$];
  logic [3:0]  got_k[$];
  logic        hold_empty = 1'b0;
  int          underflow = 0;
  int          stab_viol = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_d = '0;
  logic [3:0]  prev_k = '0;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_rd_packer #(
    .DSIZE   (DS),
    .NPACK   (NP),
    .TIMEOUT (TO)
  ) dut (
    .clkb      (clkb),
    .rstb      (rstb),
    .emptyb    (emptyb),
    .rreqb     (rreqb),
    .rdatb     (rdatb),
    .flush_req (flush_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep)
  );

  always #5 clkb = ~clkb;

  // FIFO read port: data one cycle after rreqb, registered empty.
  always @(posedge clkb) begin
    if (rreqb) begin
      if (fifo_q.size() > 0) rdatb <= fifo_q.pop_front();
      else underflow++;
    end
    emptyb <= hold_empty || (fifo_q.size() == 0);
  end

  always @(negedge clkb) begin
    if (rstb) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (!out_valid || out_data !== prev_d
          || out_keep !== prev_k)) stab_viol++;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_k.push_back(out_keep);
      end
      hold_prev = out_valid && !out_ready;
      prev_d = out_data;
      prev_k = out_keep;
    end
  end

  task automatic tick();
    @(posedge clkb);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    n_chk++;
    if (out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_data: got %h want 0", out_data);
    end
    n_chk++;
    if (out_keep !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_keep: got %b want 0", out_keep);
    end
    n_chk++;
    if (rreqb !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rreqb: got %b want 0", rreqb);
    end
    rstb = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    int nreq = 0;
    got_d.delete();
    got_k.delete();
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rreqb) nreq++;
    end
    n_chk++;
    if (nreq != 4) begin
      n_fail++;
      $display("FAIL single_rreq: got %0d want 4", nreq);
    end
    n_chk++;
    if (got_d.size() != 1) begin
      n_fail++;
      $display("FAIL single_cnt: got %0d want 1", got_d.size());
    end else begin
      n_chk++;
      if (got_d[0] !== 32'h44332211) begin
        n_fail++;
        $display("FAIL single_data: got %h want 44332211", got_d[0]);
      end
      n_chk++;
      if (got_k[0] !== 4'b1111) begin
        n_fail++;
        $display("FAIL single_keep: got %b want 1111", got_k[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nreq = 0;
    logic [31:0] wd [3];
    wd[0] = 32'h04030201;
    wd[1] = 32'h08070605;
    wd[2] = 32'h0C0B0A09;
    got_d.delete();
    got_k.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(8'(i));
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rreqb) nreq++;
    end
    n_chk++;
    if (nreq != 8) begin
      n_fail++;
      $display("FAIL bp_rreq: got %0d want 8", nreq);
    end
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got %b want 1", out_valid);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 30 && got_d.size() < 3; k++) tick();
    tick();
    tick();
    n_chk++;
    if (got_d.size() != 3) begin
      n_fail++;
      $display("FAIL bp_cnt: got %0d want 3", got_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (got_d[i] !== wd[i] || got_k[i] !== 4'hF) begin
          n_fail++;
          $display("FAIL bp_word%0d: got %h/%b want %h/1111",
                   i, got_d[i], got_k[i], wd[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int rise = -1;
    got_d.delete();
    got_k.delete();
    out_ready = 1'b1;
    push(8'hA1);
    push(8'hB2);
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (out_valid && rise < 0) rise = k;
    end
    n_chk++;
    if (rise != TO + 4) begin
      n_fail++;
      $display("FAIL to_rise: got %0d want %0d", rise, TO + 4);
    end
    n_chk++;
    if (got_d.size() != 1) begin
      n_fail++;
      $display("FAIL to_cnt: got %0d want 1", got_d.size());
    end else begin
      n_chk++;
      if (got_d[0] !== 32'h0000B2A1 || got_k[0] !== 4'b0011) begin
        n_fail++;
        $display("FAIL to_word: got %h/%b want 0000b2a1/0011",
                 got_d[0], got_k[0]);
      end
    end
  endtask

  task automatic test_flush();
    int n = 0;
    int lat = -1;
    got_d.delete();
    got_k.delete();
    out_ready = 1'b1;
    push(8'h5A); push(8'h6B); push(8'h7C);
    for (int k = 0; k < 10 && n < 3; k++) begin
      tick();
      if (rreqb) n++;
    end
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (got_d.size() > 0 && lat < 0) lat = k;
    end
    n_chk++;
    if (lat < 0 || lat > 5) begin
      n_fail++;
      $display("FAIL fl_lat: got %0d want 1..5", lat);
    end
    n_chk++;
    if (got_d.size() != 1) begin
      n_fail++;
      $display("FAIL fl_cnt: got %0d want 1", got_d.size());
    end else begin
      n_chk++;
      if (got_d[0] !== 32'h007C6B5A || got_k[0] !== 4'b0111) begin
        n_fail++;
        $display("FAIL fl_word: got %h/%b want 007c6b5a/0111",
                 got_d[0], got_k[0]);
      end
    end
    got_d.delete();
    got_k.delete();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    n_chk++;
    if (got_d.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_empty: got %0d words want 0", got_d.size());
    end
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    for (int k = 0; k < 12; k++) tick();
    n_chk++;
    if (got_d.size() != 1 || got_d[0] !== 32'hD4D3D2D1) begin
      n_fail++;
      $display("FAIL fl_after: got %0d words want 1 of d4d3d2d1",
               got_d.size());
    end
  endtask

  task automatic test_reset_mid();
    got_d.delete();
    got_k.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h90 + 8'(i));
    for (int k = 0; k < 11; k++) tick();
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_pre: got %b want 1", out_valid);
    end
    rstb = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 32'h0
        || out_keep !== 4'h0 || rreqb !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_async: got v%b d%h k%b r%b want all 0",
               out_valid, out_data, out_keep, rreqb);
    end
    tick();
    tick();
    rstb = 1'b0;
    got_d.delete();
    got_k.delete();
    out_ready = 1'b1;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    for (int k = 0; k < 12; k++) tick();
    n_chk++;
    if (got_d.size() != 1) begin
      n_fail++;
      $display("FAIL rm_cnt: got %0d want 1", got_d.size());
    end else begin
      n_chk++;
      if (got_d[0] !== 32'hC4C3C2C1 || got_k[0] !== 4'hF) begin
        n_fail++;
        $display("FAIL rm_word: got %h/%b want c4c3c2c1/1111",
                 got_d[0], got_k[0]);
      end
    end
  endtask

  task automatic test_random();
    int nbytes = 0;
    int bad = 0;
    int badk = 0;
    logic [31:0] d;
    logic [3:0] kp;
    logic [7:0] b;
    got_d.delete();
    got_k.delete();
    exp_q.delete();
    stab_viol = 0;
    for (int i = 0; i < 1000; i++) begin
      b = 8'($urandom);
      push(b);
      exp_q.push_back(b);
    end
    for (int k = 0; k < 6000; k++) begin
      hold_empty = ($urandom_range(0, 9) < 3);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    hold_empty = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) tick();
    while (got_d.size() > 0) begin
      d = got_d.pop_front();
      kp = got_k.pop_front();
      if (kp == 4'h0 || (kp & (kp + 4'd1)) != 4'h0) badk++;
      for (int i = 0; i < NP; i++) begin
        if (kp[i]) begin
          nbytes++;
          if (exp_q.size() == 0) bad++;
          else if (d[i*8 +: 8] !== exp_q.pop_front()) bad++;
        end else if (d[i*8 +: 8] !== 8'h00) begin
          badk++;
        end
      end
    end
    n_chk++;
    if (nbytes != 1000) begin
      n_fail++;
      $display("FAIL rnd_bytes: got %0d want 1000", nbytes);
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rnd_order: got %0d bad want 0", bad);
    end
    n_chk++;
    if (badk != 0) begin
      n_fail++;
      $display("FAIL rnd_keep: got %0d bad want 0", badk);
    end
    n_chk++;
    if (stab_viol != 0) begin
      n_fail++;
      $display("FAIL rnd_stable: got %0d want 0", stab_viol);
    end
    n_chk++;
    if (underflow != 0 || fifo_q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_fifo: got uf %0d left %0d want 0/0",
               underflow, fifo_q.size());
    end
  endtask

  initial begin
    rstb = 1'b1;
    flush_req = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the clkb domain of the asynchronous gray-pointer FIFO. It drains bytes from the FIFO's read port and packs NPACK consecutive bytes into one wide word with lane-keep bits. It presents each word on a valid/ready output register to the downstream datapath. A partial word is flushed on an explicit request or after an idle timeout, so trailing bytes never stall.

## Interface
- DSIZE, 8, FIFO data width (bits per lane)
- NPACK, 4, lanes per output word; power of two, ≥2
- TIMEOUT, 16, idle cycles with a partial word before auto-flush; ≥2
- clkb  in  1  sole clock (FIFO read domain)
- rstb  in  1  reset, asynchronous, active-high
- emptyb  in  1  FIFO empty flag
- rreqb  out  1  FIFO read request; FIFO drives rdatb one cycle later
- rdatb  in  DSIZE  FIFO read data, valid the cycle after rreqb
- flush_req  in  1  single-cycle request to emit the current partial word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word when high with out_valid
- out_data  out  DSIZE*NPACK  packed word; first byte read in lane 0 ([DSIZE-1:0])
- out_keep  out  NPACK  lane-valid bits; always contiguous from bit 0

## Operation
- Datapath: the read pipeline flag rd_pend is rreqb delayed by one cycle. On rd_pend, rdatb is captured into lane cnt of the assembly register, and cnt increments.
- cnt width is $clog2(NPACK+1). The timer width is $clog2(TIMEOUT).
- rreqb = ~emptyb & (state==S_FILL) & (cnt + rd_pend < NPACK) & ~flush_latched. It is combinational from registers and emptyb only. There is no path from out_ready.
- Output slot: a single register (out_valid/out_data/out_keep). A word loads when the slot is empty or is being accepted in the same cycle (out_valid & out_ready). The slot holds stable while out_valid & ~out_ready.
- State machine:
  - S_FILL: accumulate.
    - Capture completes the word (cnt becomes NPACK) and the slot is free: load slot with keep all-ones, cnt←0, stay.
    - Capture completes the word and the slot is busy: go to S_FULL.
    - flush_latched or timeout, with cnt>0 and rd_pend=0: load slot if free (keep = (1<<cnt)-1, unused lanes zero), cnt←0. Otherwise go to S_FLUSH.
  - S_FULL: no reads. Load slot with keep all-ones when free, cnt←0, go to S_FILL.
  - S_FLUSH: no reads. Load partial word when free, cnt←0, go to S_FILL.
- flush_latched:
  - Set by flush_req.
  - Cleared when a partial flush loads the slot, or when a full word completes with no bytes remaining.
  - flush_req with cnt=0 and rd_pend=0 is ignored (no empty words are ever emitted).
  - flush_req while rd_pend=1 takes effect after that byte is captured, so the byte is included.
- Idle timer:
  - Counts while state==S_FILL, 0<cnt<NPACK, rd_pend=0, rreqb=0.
  - Clears on any capture or when cnt=0.
  - Timeout fires when the count reaches TIMEOUT-1.
- Reset: asynchronously, rreqb=0, out_valid=0, out_data=0, out_keep=0, cnt=0, rd_pend=0, timer=0, flush_latched=0, state=S_FILL.
- Reset mid-operation: partial bytes and any in-flight byte are discarded. The FIFO pointer has already advanced, so these bytes are lost by design.

## Timing
- Read latency: rreqb at cycle N puts the byte in the assembly register at N+1 and allows it to appear in out_data at N+2 at the earliest.
- Steady-state throughput: NPACK bytes per NPACK+1 cycles. The read gate stalls one cycle per word while the last byte is in flight.
- Timeout flush: out_valid rises TIMEOUT+1 cycles after the last capture when the slot is free.
- Simultaneous events:
  - Slot accept and new load in the same cycle: out_valid stays high and the new data appears.
  - flush_req in the same cycle as a completing capture: the full word is emitted and the flush is consumed.

## Structure
- Package fifo_pkg holds:
  - the state enum (S_FILL, S_FULL, S_FLUSH)
  - localparams derived from NPACK/TIMEOUT (cnt and timer widths)
  - lane-keep helper constants
- Sub-module fifo_idle_timer (clear, enable, TIMEOUT parameter, expire pulse).
- The assembly, state machine and slot stay in fifo_rd_packer. Expected size is about 200 lines.

## Test plan
- Write 0x11,0x22,0x33,0x44 with out_ready=1 → one word: out_data=0x44332211, out_keep=4'b1111, rreqb high for 4 of 5 cycles.
- Write 12 bytes back-to-back with out_ready held 0 for 20 cycles → rreqb drops after the first 8 bytes (slot + S_FULL). Releasing out_ready yields 3 words in order with no loss or duplication.
- Write 0xA1,0xB2 then stop → after TIMEOUT idle cycles, out_data=0x0000B2A1, out_keep=4'b0011.
- Pulse flush_req the cycle after rreqb for byte 3 → word carries 3 bytes, out_keep=4'b0111. flush_req with nothing buffered → no output.
- Assert rstb while cnt=2 and out_valid=1 → all outputs 0 immediately. After release, the next 4 bytes form a clean word with keep 4'b1111.
- Random emptyb/out_ready toggling over 1000 bytes → the scoreboard matches byte order. out_data and out_keep stay stable while out_valid & ~out_ready.
